// File: rtl/flash_raid_pkg.sv
// rtl/flash_raid_pkg.sv - shared encodings for the flash access arbiter
package flash_raid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [1:0] MODE_MAIN      = 2'b00;
  localparam logic [1:0] MODE_SECONDARY = 2'b01;
  localparam logic [1:0] MODE_SHARE     = 2'b10;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_MSB = 1;
  localparam int CFG_R0_EN    = 2;
  localparam int CFG_R1_EN    = 3;
  localparam int CFG_R0_SEL   = 4;
  localparam int CFG_R1_SEL   = 5;
  localparam int CFG_HOST_SEL = 6;

  localparam logic FLASH_MAIN      = 1'b0;
  localparam logic FLASH_SECONDARY = 1'b1;

endpackage

// File: rtl/flash_range_decoder.sv
// rtl/flash_range_decoder.sv - maps a transaction address and mode to the target flash
module flash_range_decoder
  import flash_raid_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              range0_en,
  input  logic              range1_en,
  input  logic              range0_sel,
  input  logic              range1_sel,
  input  logic [ADDR_W-1:0] addr0_start,
  input  logic [ADDR_W-1:0] addr0_end,
  input  logic [ADDR_W-1:0] addr1_start,
  input  logic [ADDR_W-1:0] addr1_end,
  output logic              flash_sel
);

  logic hit0;
  logic hit1;

  // An inverted window (start > end) can never satisfy both bounds.
  assign hit0 = range0_en && (addr >= addr0_start) && (addr <= addr0_end);
  assign hit1 = range1_en && (addr >= addr1_start) && (addr <= addr1_end);

  always_comb begin
    flash_sel = FLASH_MAIN;
    if (mode == MODE_SECONDARY) begin
      flash_sel = FLASH_SECONDARY;
    end else if (mode == MODE_SHARE) begin
      if (hit0)      flash_sel = range0_sel;
      else if (hit1) flash_sel = range1_sel;
    end
  end

endmodule

// File: rtl/flash_access_arbiter.sv
// rtl/flash_access_arbiter.sv - two-host arbiter for the shared SPI flash pair
// Optional grant counters are built when ARB_STATS_EN is defined.
module flash_access_arbiter
  import flash_raid_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cfg_control,
  input  logic [ADDR_W-1:0] addr0_start,
  input  logic [ADDR_W-1:0] addr0_end,
  input  logic [ADDR_W-1:0] addr1_start,
  input  logic [ADDR_W-1:0] addr1_end,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [1:0]        done,
  output logic [1:0]        gnt,
  output logic              flash_sel,
  output logic              flash_en,
  output logic              timeout_flag,
  output logic [15:0]       grant_count0,
  output logic [15:0]       grant_count1
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              target_q, target_d;
  logic              ptr_q, ptr_d;
  logic              timeout_q, timeout_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic [1:0]        mode;
  logic              host_sel;
  logic [1:0]        elig;
  logic              winner;
  logic [ADDR_W-1:0] win_addr;
  logic              dec_sel;

  assign mode     = cfg_control[CFG_MODE_MSB:CFG_MODE_LSB];
  assign host_sel = cfg_control[CFG_HOST_SEL];

  always_comb begin
    elig = 2'b00;
    case (mode)
      MODE_MAIN, MODE_SECONDARY: elig[host_sel] = req[host_sel];
      MODE_SHARE:                elig = req;
      default:                   elig = 2'b00;
    endcase
    winner = (elig == 2'b11) ? ptr_q : elig[1];
  end

  assign win_addr = winner ? req_addr1 : req_addr0;

  flash_range_decoder #(.ADDR_W(ADDR_W)) u_decoder (
    .mode        (mode),
    .addr        (win_addr),
    .range0_en   (cfg_control[CFG_R0_EN]),
    .range1_en   (cfg_control[CFG_R1_EN]),
    .range0_sel  (cfg_control[CFG_R0_SEL]),
    .range1_sel  (cfg_control[CFG_R1_SEL]),
    .addr0_start (addr0_start),
    .addr0_end   (addr0_end),
    .addr1_start (addr1_start),
    .addr1_end   (addr1_end),
    .flash_sel   (dec_sel)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    target_d  = target_q;
    ptr_d     = ptr_q;
    timeout_d = timeout_q;
    wdog_d    = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d   = ST_GRANT;
          owner_d   = winner;
          target_d  = dec_sel;
          ptr_d     = ~winner;
          timeout_d = 1'b0;
          wdog_d    = '0;
        end
      end
      ST_GRANT: begin
        wdog_d = wdog_q + 1'b1;
        // A real done wins over a watchdog expiry in the same cycle.
        if (done[owner_q]) begin
          state_d = ST_RELEASE;
        end else if (wdog_q == WD_LAST) begin
          state_d   = ST_RELEASE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      target_q  <= FLASH_MAIN;
      ptr_q     <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      target_q  <= target_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  assign flash_en     = (state_q == ST_GRANT);
  assign gnt          = flash_en ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign flash_sel    = flash_en & target_q;
  assign timeout_flag = timeout_q;

`ifdef ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        grant_now;

  assign grant_now = (state_q == ST_IDLE) && (|elig);

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant_now && !winner && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (grant_now &&  winner && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
`else
  assign grant_count0 = 16'd0;
  assign grant_count1 = 16'd0;
`endif

endmodule

// File: tb/tb_flash_access_arbiter.sv
// tb/tb_flash_access_arbiter.sv - directed vector bench for flash_access_arbiter
module tb_flash_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_control;
  logic [23:0] addr0_start, addr0_end, addr1_start, addr1_end;
  logic [1:0]  req;
  logic [23:0] req_addr0, req_addr1;
  logic [1:0]  done;
  logic [1:0]  gnt;
  logic        flash_sel, flash_en, timeout_flag;
  logic [15:0] grant_count0, grant_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_access_arbiter #(.ADDR_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_control  (cfg_control),
    .addr0_start  (addr0_start),
    .addr0_end    (addr0_end),
    .addr1_start  (addr1_start),
    .addr1_end    (addr1_end),
    .req          (req),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .done         (done),
    .gnt          (gnt),
    .flash_sel    (flash_sel),
    .flash_en     (flash_en),
    .timeout_flag (timeout_flag),
    .grant_count0 (grant_count0),
    .grant_count1 (grant_count1)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  cfg;
    logic [1:0]  req;
    logic [1:0]  done;
    logic [23:0] a0;
    logic [23:0] a1;
    logic [1:0]  gnt;
    logic        sel;
    logic        en;
    logic        tf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [7:0] c, logic [1:0] q, logic [1:0] d,
                              logic [23:0] a0, logic [23:0] a1,
                              logic [1:0] g, logic s, logic e, logic t);
    vec_t v;
    v.rst = r; v.cfg = c; v.req = q; v.done = d; v.a0 = a0; v.a1 = a1;
    v.gnt = g; v.sel = s; v.en = e; v.tf = t;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_exp [4];
  logic [15:0] exp_c0, exp_c1;

  initial begin
    rst = 1'b1; cfg_control = 8'h00; req = 2'b00; done = 2'b00;
    req_addr0 = 24'h0; req_addr1 = 24'h0;
    addr0_start = 24'h001000; addr0_end = 24'h001FFF;
    addr1_start = 24'h001800; addr1_end = 24'h003FFF;

    //   rst  cfg    req    done   a0           a1           gnt    sel   en    tf
    add(1'b1, 8'h1C, 2'b00, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1C, 2'b11, 2'b00, 24'h0,       24'h0,       2'b01, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h1C, 2'b11, 2'b10, 24'h0,       24'h0,       2'b01, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h1C, 2'b11, 2'b01, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1C, 2'b11, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1C, 2'b11, 2'b00, 24'h0,       24'h0,       2'b01, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h1C, 2'b11, 2'b01, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h5D, 2'b01, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h5D, 2'b01, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h5D, 2'b11, 2'b00, 24'h0,       24'h0,       2'b10, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h5D, 2'b00, 2'b10, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b10, 2'b00, 24'h0,       24'h002000,  2'b10, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h5D, 2'b00, 2'b01, 24'h0,       24'h002000,  2'b10, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h5D, 2'b00, 2'b10, 24'h0,       24'h002000,  2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b01, 2'b00, 24'h001900,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b01, 2'b00, 24'h001900,  24'h0,       2'b01, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b01, 24'h001900,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b00, 24'h100000,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b01, 2'b00, 24'h100000,  24'h0,       2'b01, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b01, 24'h100000,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1F, 2'b11, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1F, 2'b11, 2'b00, 24'h0,       24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b01, 2'b00, 24'h001FFF,  24'h0,       2'b01, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b01, 24'h001FFF,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b00, 24'h000FFF,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h1E, 2'b01, 2'b00, 24'h000FFF,  24'h0,       2'b01, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h1E, 2'b00, 2'b01, 24'h000FFF,  24'h0,       2'b00, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; cfg_control = vecs[i].cfg; req = vecs[i].req;
      done = vecs[i].done; req_addr0 = vecs[i].a0; req_addr1 = vecs[i].a1;
      step();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_sel", i), 32'(flash_sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d_en", i), 32'(flash_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_tf", i), 32'(timeout_flag), 32'(vecs[i].tf));
    end

    // Watchdog: owner never signals done, grant must end after 16 cycles.
    rst = 1'b1; req = 2'b00; done = 2'b00; step();
    rst = 1'b0; cfg_control = 8'h1C; req = 2'b01; step();
    chk("wd_first_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    for (int k = 1; k < 16; k++) begin
      step();
      chk($sformatf("wd_hold%0d", k), 32'(gnt), 32'h1);
    end
    step();
    chk("wd_drop_gnt", 32'(gnt), 32'h0);
    chk("wd_drop_en", 32'(flash_en), 32'h0);
    chk("wd_flag_set", 32'(timeout_flag), 32'h1);
    step();
    chk("wd_flag_sticky", 32'(timeout_flag), 32'h1);
    req = 2'b01; step();
    chk("wd_regrant", 32'(gnt), 32'h1);
    chk("wd_flag_clear", 32'(timeout_flag), 32'h0);
    req = 2'b00; done = 2'b01; step();
    done = 2'b00; step();

    // Share-mode round robin with requests held continuously.
    rst = 1'b1; step();
    rst = 1'b0; cfg_control = 8'h1E; req_addr0 = 24'h100000; req_addr1 = 24'h100000;
    req = 2'b11; step();
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(rr_exp[i]));
      step();
      chk($sformatf("rr%0d_hold1", i), 32'(gnt), 32'(rr_exp[i]));
      step();
      chk($sformatf("rr%0d_hold2", i), 32'(gnt), 32'(rr_exp[i]));
      done = rr_exp[i]; step();
      chk($sformatf("rr%0d_release", i), 32'(gnt), 32'h0);
      done = 2'b00; step();
      chk($sformatf("rr%0d_idle", i), 32'(gnt), 32'h0);
      step();
    end
    chk("rr_fifth_gnt", 32'(gnt), 32'h1);
`ifdef ARB_STATS_EN
    exp_c0 = 16'd3; exp_c1 = 16'd2;
`else
    exp_c0 = 16'd0; exp_c1 = 16'd0;
`endif
    chk("cnt0_before_rst", 32'(grant_count0), 32'(exp_c0));
    chk("cnt1_before_rst", 32'(grant_count1), 32'(exp_c1));

    rst = 1'b1; step();
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    chk("rst_mid_en", 32'(flash_en), 32'h0);
    chk("cnt0_after_rst", 32'(grant_count0), 32'h0);
    chk("cnt1_after_rst", 32'(grant_count1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
